// File: rtl/miner_pkg.sv
// Shared types and helpers for the nonce scanning controller.
package miner_pkg;

  localparam int NONCE_LSB  = 384;
  localparam int NONCE_MSB  = 415;
  localparam int INFLIGHT_W = 4;

  typedef struct packed {
    logic [255:0] midstate;
    logic [511:0] block;
  } job_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } scan_state_e;

  // The nonce travels little-endian inside the block header.
  function automatic logic [31:0] byteswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/digest_target_cmp.sv
// Registered leading-zero target check: hit_o pulses one cycle after a valid
// digest whose low ZERO_BITS bits are all zero.
module digest_target_cmp #(
  parameter int ZERO_BITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [255:0] digest_i,
  output logic         hit_o
);

  logic hit_q, hit_d;

  assign hit_d = valid_i && (digest_i[ZERO_BITS-1:0] == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/nonce_scan_ctrl.sv
// Sweeps the nonce of one mining job through the SHA-256d core and reports hits.
// Optional macro MINER_HASHRATE_CNT_EN enables the saturating hash_count.
module nonce_scan_ctrl
  import miner_pkg::*;
#(
  parameter int ZERO_BITS    = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int STOP_ON_FIND = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  input  logic [767:0] job_data,
  output logic         job_ready,
  output logic         hash_req_valid,
  input  logic         hash_req_ready,
  output logic [255:0] hash_midstate,
  output logic [511:0] hash_block,
  input  logic         hash_resp_valid,
  input  logic [255:0] hash_resp_digest,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic         busy,
  output logic         exhausted,
  output logic [31:0]  hash_count
);

  localparam logic [INFLIGHT_W-1:0] MAX_IF = INFLIGHT_W'(MAX_INFLIGHT);
  localparam bit STOP = (STOP_ON_FIND != 0);

  scan_state_e           state_q;
  job_t                  job_q;
  logic [31:0]           issue_nonce_q, check_nonce_q, pipe_nonce_q, found_nonce_q;
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
  logic                  last_issued_q, hit_seen_q, exhausted_q;
  logic                  cmp_hit, stop_now, req_fire, resp_ok, check_en, job_accept;

  assign job_ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign job_accept = job_ready && job_valid;

  // A registered hit kills the request in its own cycle so nothing issues past it.
  assign stop_now       = STOP && cmp_hit;
  assign hash_req_valid = (state_q == RUN) && (inflight_q < MAX_IF) && !last_issued_q && !stop_now;
  assign req_fire       = hash_req_valid && hash_req_ready;
  assign resp_ok        = hash_resp_valid && (inflight_q != '0);
  assign check_en       = resp_ok && !(STOP && (hit_seen_q || cmp_hit));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inflight_d = inflight_q;
    if (req_fire && !resp_ok)      inflight_d = inflight_q + INFLIGHT_W'(1);
    else if (!req_fire && resp_ok) inflight_d = inflight_q - INFLIGHT_W'(1);
  end

  always_comb begin
    hash_block = job_q.block;
    hash_block[NONCE_MSB:NONCE_LSB] = byteswap32(issue_nonce_q);
  end

  assign hash_midstate = job_q.midstate;
  assign found_valid   = cmp_hit;
  assign found_nonce   = cmp_hit ? pipe_nonce_q : found_nonce_q;
  assign exhausted     = exhausted_q;

  digest_target_cmp #(.ZERO_BITS(ZERO_BITS)) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (check_en),
    .digest_i (hash_resp_digest),
    .hit_o    (cmp_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      job_q         <= '0;
      issue_nonce_q <= '0;
      check_nonce_q <= '0;
      pipe_nonce_q  <= '0;
      found_nonce_q <= '0;
      inflight_q    <= '0;
      last_issued_q <= 1'b0;
      hit_seen_q    <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (req_fire) issue_nonce_q <= issue_nonce_q + 32'd1;
      if (resp_ok) begin
        pipe_nonce_q  <= check_nonce_q;
        check_nonce_q <= check_nonce_q + 32'd1;
      end
      if (cmp_hit) begin
        hit_seen_q    <= 1'b1;
        found_nonce_q <= pipe_nonce_q;
      end

      unique case (state_q)
        IDLE, DONE: begin
          if (job_valid) begin
            job_q         <= job_t'(job_data);
            issue_nonce_q <= byteswap32(job_data[NONCE_MSB:NONCE_LSB]);
            check_nonce_q <= byteswap32(job_data[NONCE_MSB:NONCE_LSB]);
            inflight_q    <= '0;
            last_issued_q <= 1'b0;
            hit_seen_q    <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            state_q       <= RUN;
          end
        end
        RUN: begin
          if (req_fire && issue_nonce_q == '1) last_issued_q <= 1'b1;
          if (stop_now || (req_fire && issue_nonce_q == '1)) state_q <= DRAIN;
        end
        DRAIN: begin
          // A hit on the final response shows up in the same cycle inflight reaches 0.
          if (inflight_q == '0) begin
            state_q     <= DONE;
            exhausted_q <= !(hit_seen_q || cmp_hit);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MINER_HASHRATE_CNT_EN
  logic [31:0] hash_count_q, hash_count_d;

  always_comb begin
    hash_count_d = hash_count_q;
    if (job_accept)                          hash_count_d = '0;
    else if (resp_ok && hash_count_q != '1)  hash_count_d = hash_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hash_count_q <= '0;
    else     hash_count_q <= hash_count_d;
  end

  assign hash_count = hash_count_q;
`else
  assign hash_count = '0;
`endif

  resp_underflow_a: assert property (@(posedge clk) disable iff (rst)
    hash_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// Directed bench for nonce_scan_ctrl: stop-on-find, exhaustion, backpressure,
// inflight cap, reset mid-job, and a keep-scanning instance.
module tb_nonce_scan_ctrl;

  localparam logic [511:0] BLK_BASE = {16{32'h1357_9BDF}};
  localparam logic [255:0] MID_A    = {8{32'h0123_4567}};
  localparam logic [255:0] MID_B    = {8{32'h89AB_CDEF}};
  localparam logic [255:0] D_PASS   = {160'hFACE, 32'h0, 32'h1, 32'h0};
  localparam logic [255:0] D_FAIL31 = 256'h8000_0000;
  localparam logic [255:0] D_FAIL0  = 256'h1;
  localparam logic [255:0] D_FAIL   = {224'hBEEF, 32'h0010_0000};
`ifdef MINER_HASHRATE_CNT_EN
  localparam logic [31:0] HC1 = 32'd1, HC3 = 32'd3, HC8 = 32'd8;
`else
  localparam logic [31:0] HC1 = 32'd0, HC3 = 32'd0, HC8 = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_job_valid, a_job_ready, a_req_valid, a_req_ready, a_resp_valid;
  logic [767:0] a_job_data;
  logic [255:0] a_midstate, a_resp_digest;
  logic [511:0] a_block;
  logic         a_found_valid, a_busy, a_exhausted;
  logic [31:0]  a_found_nonce, a_hash_count;

  logic         b_job_valid, b_job_ready, b_req_valid, b_req_ready, b_resp_valid;
  logic [767:0] b_job_data;
  logic [255:0] b_midstate, b_resp_digest;
  logic [511:0] b_block;
  logic         b_found_valid, b_busy, b_exhausted;
  logic [31:0]  b_found_nonce, b_hash_count;

  nonce_scan_ctrl u_dut (
    .clk(clk), .rst(rst), .job_valid(a_job_valid), .job_data(a_job_data), .job_ready(a_job_ready),
    .hash_req_valid(a_req_valid), .hash_req_ready(a_req_ready), .hash_midstate(a_midstate),
    .hash_block(a_block), .hash_resp_valid(a_resp_valid), .hash_resp_digest(a_resp_digest),
    .found_valid(a_found_valid), .found_nonce(a_found_nonce), .busy(a_busy),
    .exhausted(a_exhausted), .hash_count(a_hash_count)
  );

  nonce_scan_ctrl #(.STOP_ON_FIND(0)) u_dut_ns (
    .clk(clk), .rst(rst), .job_valid(b_job_valid), .job_data(b_job_data), .job_ready(b_job_ready),
    .hash_req_valid(b_req_valid), .hash_req_ready(b_req_ready), .hash_midstate(b_midstate),
    .hash_block(b_block), .hash_resp_valid(b_resp_valid), .hash_resp_digest(b_resp_digest),
    .found_valid(b_found_valid), .found_nonce(b_found_nonce), .busy(b_busy),
    .exhausted(b_exhausted), .hash_count(b_hash_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bs(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [511:0] exp_blk(input logic [31:0] nonce);
    logic [511:0] blk;
    blk = BLK_BASE;
    blk[415:384] = bs(nonce);
    return blk;
  endfunction

  function automatic logic [767:0] mk_job(input logic [255:0] mid, input logic [31:0] start);
    return {mid, exp_blk(start)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, responded, hits;
    logic fired;
    a_job_valid = 0; a_job_data = '0; a_req_ready = 0; a_resp_valid = 0; a_resp_digest = '0;
    b_job_valid = 0; b_job_data = '0; b_req_ready = 0; b_resp_valid = 0; b_resp_digest = '0;

    #2;
    check("rst_busy", a_busy, 0);
    check("rst_job_ready", a_job_ready, 1);
    check("rst_req_valid", a_req_valid, 0);
    check("rst_found_valid", a_found_valid, 0);
    check("rst_found_nonce", a_found_nonce, 0);
    check("rst_exhausted", a_exhausted, 0);
    check("rst_hash_count", a_hash_count, 0);
    check("rst_block", a_block, 0);
    #10 rst = 0;
    tick;

    // Job 1: start 0, hit on third response, stop on find.
    a_job_data = mk_job(MID_A, 32'h0); a_job_valid = 1;
    tick; a_job_valid = 0;
    check("j1_busy", a_busy, 1);
    check("j1_job_ready", a_job_ready, 0);
    check("j1_req_valid", a_req_valid, 1);
    check("j1_block0", a_block, exp_blk(32'h0));
    check("j1_midstate", a_midstate, MID_A);
    a_req_ready = 1; tick;
    a_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", a_req_valid, 1);
      check("stall_block", a_block, exp_blk(32'h1));
      tick;
    end
    a_req_ready = 1; tick;
    check("j1_block2", a_block, exp_blk(32'h2));
    tick; tick;
    check("cap_valid_low", a_req_valid, 0);
    check("cap_block4", a_block, exp_blk(32'h4));
    tick;
    check("cap_hold1", a_req_valid, 0);
    tick;
    check("cap_hold2", a_req_valid, 0);
    a_req_ready = 0;
    a_resp_valid = 1; a_resp_digest = D_FAIL31; tick;
    check("resp0_reopen", a_req_valid, 1);
    check("resp0_fail_bit31", a_found_valid, 0);
    a_resp_digest = D_FAIL0; tick;
    check("resp1_fail_bit0", a_found_valid, 0);
    a_resp_digest = D_PASS; tick; a_resp_valid = 0;
    check("hit_pulse", a_found_valid, 1);
    check("hit_nonce", a_found_nonce, 32'h2);
    check("hit_no_req", a_req_valid, 0);
    tick;
    check("drain_pulse_once", a_found_valid, 0);
    check("drain_busy", a_busy, 1);
    check("drain_no_req", a_req_valid, 0);
    a_resp_valid = 1; a_resp_digest = D_PASS; tick; a_resp_valid = 0;
    check("drain_unchecked", a_found_valid, 0);
    tick;
    check("done_busy", a_busy, 0);
    check("done_exhausted", a_exhausted, 0);
    check("done_job_ready", a_job_ready, 1);
    check("done_found_nonce", a_found_nonce, 32'h2);

    // Job 2: start FFFFFFFD, no hits, runs to exhaustion.
    a_job_data = mk_job(MID_B, 32'hFFFF_FFFD); a_job_valid = 1;
    tick; a_job_valid = 0;
    check("j2_busy", a_busy, 1);
    check("j2_hash_count_clr", a_hash_count, 0);
    check("j2_found_nonce_clr", a_found_nonce, 0);
    check("j2_midstate", a_midstate, MID_B);
    check("j2_block_fd", a_block, exp_blk(32'hFFFF_FFFD));
    a_req_ready = 1; tick;
    check("j2_block_fe", a_block, exp_blk(32'hFFFF_FFFE));
    tick;
    check("j2_block_ff", a_block, exp_blk(32'hFFFF_FFFF));
    check("j2_valid_ff", a_req_valid, 1);
    tick;
    check("j2_last_stop", a_req_valid, 0);
    tick;
    check("j2_last_hold", a_req_valid, 0);
    a_req_ready = 0;
    a_resp_valid = 1; a_resp_digest = D_FAIL31; tick;
    check("j2_r0", a_found_valid, 0);
    a_resp_digest = D_FAIL0; tick;
    check("j2_r1", a_found_valid, 0);
    a_resp_digest = D_FAIL; tick; a_resp_valid = 0;
    check("j2_r2", a_found_valid, 0);
    tick;
    check("j2_done_busy", a_busy, 0);
    check("j2_exhausted", a_exhausted, 1);
    check("j2_hash_count", a_hash_count, HC3);
    tick;
    check("j2_exhausted_sticky", a_exhausted, 1);

    // Job 3: reset with three requests in flight, then a fresh job.
    a_job_data = mk_job(MID_A, 32'h1234_5678); a_job_valid = 1;
    tick; a_job_valid = 0;
    a_req_ready = 1; tick; tick; tick; a_req_ready = 0;
    check("j3_busy", a_busy, 1);
    #2 rst = 1;
    #1;
    check("async_rst_busy", a_busy, 0);
    check("async_rst_req", a_req_valid, 0);
    check("async_rst_ready", a_job_ready, 1);
    check("async_rst_block", a_block, 0);
    check("async_rst_exh", a_exhausted, 0);
    #2 rst = 0;
    tick;
    a_job_data = mk_job(MID_B, 32'h0000_00A0); a_job_valid = 1;
    tick; a_job_valid = 0;
    check("j4_block", a_block, exp_blk(32'h0000_00A0));
    check("j4_hash_count", a_hash_count, 0);
    a_req_ready = 1; tick; a_req_ready = 0;
    check("j4_block_next", a_block, exp_blk(32'h0000_00A1));
    a_resp_valid = 1; a_resp_digest = D_FAIL; tick; a_resp_valid = 0;
    check("j4_no_hit", a_found_valid, 0);
    check("j4_count1", a_hash_count, HC1);
    check("j4_req_valid", a_req_valid, 1);

    // Keep-scanning instance: start FFFFFFF8, hits at start+1 and start+5.
    b_job_data = mk_job(MID_A, 32'hFFFF_FFF8); b_job_valid = 1;
    tick; b_job_valid = 0; b_req_ready = 1;
    issued = 0; responded = 0; hits = 0;
    for (int cyc = 0; cyc < 60 && b_busy; cyc++) begin
      b_resp_valid  = (issued > responded);
      b_resp_digest = (responded == 1 || responded == 5) ? D_PASS : D_FAIL;
      fired = b_req_valid;
      if (fired) check("ns_issue_block", b_block, exp_blk(32'(32'hFFFF_FFF8 + issued)));
      tick;
      if (fired) issued++;
      if (b_resp_valid) responded++;
      if (b_found_valid) begin
        check("ns_hit_nonce", b_found_nonce, (hits == 0) ? 32'hFFFF_FFF9 : 32'hFFFF_FFFD);
        hits++;
      end
    end
    b_resp_valid = 0; b_req_ready = 0;
    check("ns_hits", hits, 2);
    check("ns_issued", issued, 8);
    check("ns_busy", b_busy, 0);
    check("ns_exhausted", b_exhausted, 0);
    check("ns_found_hold", b_found_nonce, 32'hFFFF_FFFD);
    check("ns_hash_count", b_hash_count, HC8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
